// File: rtl/mdu_issue_if.sv
// Issue-controller <-> MDU channel: operation launch, operands, and busy/HI/LO return.
interface mdu_issue_if;
    logic        start;
    logic        mt;
    logic [2:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, mt, MDU_op, A, B, input busy, HI, LO);
    modport slave  (input start, mt, MDU_op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_issue.sv
// E-stage issue controller for the MDU: decode, latency countdown, D-stall and mfhi/mflo result slot.
// Optional consistency checker enabled by defining MDU_ISSUE_CHECK_EN.
module mdu_issue #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              res,
    input  logic              D_md,
    input  logic              E_valid,
    input  logic [3:0]        E_md_type,
    input  logic [31:0]       E_rs,
    input  logic [31:0]       E_rt,
    mdu_issue_if.master       mdu,
    output logic              stall_D,
    output logic [31:0]       M_md_res,
    output logic              M_md_wen,
    output logic              md_err
);
    localparam logic [3:0] MUL_L = 4'(MUL_LAT);
    localparam logic [3:0] DIV_L = 4'(DIV_LAT);

    logic       start_c;
    logic       mt_c;
    logic       is_div;
    logic       rd_hi;
    logic       rd_lo;
    logic [2:0] op_c;
    logic [3:0] pend;

    always_comb begin
        start_c = 1'b0;
        mt_c    = 1'b0;
        is_div  = 1'b0;
        rd_hi   = 1'b0;
        rd_lo   = 1'b0;
        op_c    = 3'b111;
        if (E_valid) begin
            case (E_md_type)
                4'd1: begin start_c = 1'b1; op_c = 3'b011; end
                4'd2: begin start_c = 1'b1; op_c = 3'b010; end
                4'd3: begin start_c = 1'b1; is_div = 1'b1; op_c = 3'b101; end
                4'd4: begin start_c = 1'b1; is_div = 1'b1; op_c = 3'b100; end
                4'd5: rd_hi = 1'b1;
                4'd6: rd_lo = 1'b1;
                4'd7: begin mt_c = 1'b1; op_c = 3'b001; end
                4'd8: begin mt_c = 1'b1; op_c = 3'b000; end
                default: ;
            endcase
        end
    end

    assign mdu.start  = start_c;
    assign mdu.mt     = mt_c;
    assign mdu.MDU_op = op_c;
    assign mdu.A      = E_rs;
    assign mdu.B      = E_rt;

    // pend==1 is the MDU's final busy cycle; HI/LO land on its closing edge, so no stall there.
    assign stall_D = D_md & (start_c | (pend > 4'd1));

    always_ff @(posedge clk) begin
        if (res) begin
            pend <= 4'd0;
        end else if (start_c) begin
            pend <= is_div ? DIV_L : MUL_L;
        end else if (pend != 4'd0) begin
            pend <= pend - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            M_md_res <= 32'd0;
            M_md_wen <= 1'b0;
        end else if (rd_hi) begin
            M_md_res <= mdu.HI;
            M_md_wen <= 1'b1;
        end else if (rd_lo) begin
            M_md_res <= mdu.LO;
            M_md_wen <= 1'b1;
        end else begin
            M_md_wen <= 1'b0;
        end
    end

`ifdef MDU_ISSUE_CHECK_EN
    logic md_err_q;

    always_ff @(posedge clk) begin
        if (res) begin
            md_err_q <= 1'b0;
        end else if ((mdu.busy != (pend != 4'd0)) || ((start_c | mt_c) && (pend > 4'd1))) begin
            md_err_q <= 1'b1;
        end
    end

    assign md_err = md_err_q;
`else
    assign md_err = 1'b0;
`endif
endmodule

// File: tb/tb_mdu_issue.sv
// Directed-vector bench for mdu_issue with a small behavioural MDU supplying busy/HI/LO.
module tb_mdu_issue;
    logic        clk = 1'b0;
    logic        res;
    logic        D_md;
    logic        E_valid;
    logic [3:0]  E_md_type;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        stall_D;
    logic [31:0] M_md_res;
    logic        M_md_wen;
    logic        md_err;
    logic        busy_force;

    int n_checks = 0;
    int n_errors = 0;

    mdu_issue_if mif ();

    mdu_issue #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk       (clk),
        .res       (res),
        .D_md      (D_md),
        .E_valid   (E_valid),
        .E_md_type (E_md_type),
        .E_rs      (E_rs),
        .E_rt      (E_rt),
        .mdu       (mif),
        .stall_D   (stall_D),
        .M_md_res  (M_md_res),
        .M_md_wen  (M_md_wen),
        .md_err    (md_err)
    );

    always #5 clk = ~clk;

    // Behavioural MDU: accepts start only when idle, writes HI/LO on the edge closing its last busy cycle.
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    always_comb begin
        prod_s = 64'(longint'($signed(a_q)) * longint'($signed(b_q)));
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        quo_s  = 32'd0;
        rem_s  = 32'd0;
        quo_u  = 32'd0;
        rem_u  = 32'd0;
        if (b_q != 32'd0) begin
            quo_s = $signed(a_q) / $signed(b_q);
            rem_s = $signed(a_q) % $signed(b_q);
            quo_u = a_q / b_q;
            rem_u = a_q % b_q;
        end
    end

    always @(posedge clk) begin
        if (res) begin
            cnt  <= 4'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            if (cnt == 4'd0 && mif.start) begin
                cnt  <= mif.MDU_op[2] ? 4'd10 : 4'd5;
                op_q <= mif.MDU_op;
                a_q  <= mif.A;
                b_q  <= mif.B;
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    case (op_q)
                        3'b011:  begin hi_q <= prod_s[63:32]; lo_q <= prod_s[31:0]; end
                        3'b010:  begin hi_q <= prod_u[63:32]; lo_q <= prod_u[31:0]; end
                        3'b101:  begin hi_q <= rem_s; lo_q <= quo_s; end
                        default: begin hi_q <= rem_u; lo_q <= quo_u; end
                    endcase
                end
            end
            if (cnt == 4'd0 && mif.mt) begin
                if (mif.MDU_op[0]) hi_q <= mif.A;
                else               lo_q <= mif.A;
            end
        end
    end

    assign mif.busy = (cnt != 4'd0) | busy_force;
    assign mif.HI   = hi_q;
    assign mif.LO   = lo_q;

    typedef struct {
        logic        d_md;
        logic        e_valid;
        logic [3:0]  typ;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        x_stall;
        logic        x_start;
        logic        x_mt;
        logic [2:0]  x_op;
        logic [3:0]  x_pend;
        logic        x_wen;
        logic        chk_res;
        logic [31:0] x_res;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic d, input logic v, input logic [3:0] t,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic st, input logic sa, input logic m, input logic [2:0] op,
                       input logic [3:0] p, input logic w, input logic cr, input logic [31:0] r);
        vec_t e;
        e.d_md = d; e.e_valid = v; e.typ = t; e.rs = rs; e.rt = rt;
        e.x_stall = st; e.x_start = sa; e.x_mt = m; e.x_op = op;
        e.x_pend = p; e.x_wen = w; e.chk_res = cr; e.x_res = r;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic v, input logic [3:0] t,
                         input logic [31:0] rs, input logic [31:0] rt);
        D_md = d; E_valid = v; E_md_type = t; E_rs = rs; E_rt = rt;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        busy_force = 1'b0;
        res = 1'b1;
        drive(0, 0, 0, 0, 0);

        // mult 7*6, D-stage MD instruction held; mflo enters E at C6
        add(1, 1, 1, 32'd7, 32'd6, 1, 1, 0, 3'b011, 0, 0, 1, 32'd0);
        for (int k = 5; k >= 2; k--) add(1, 0, 0, 0, 0, 1, 0, 0, 3'b111, 4'(k), 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 0, 0, 0);
        add(1, 1, 6, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 1, 32'd42);
        // div -7/2 then mfhi at C11
        add(1, 1, 3, 32'hFFFF_FFF9, 32'd2, 1, 1, 0, 3'b101, 0, 0, 1, 32'd42);
        for (int k = 10; k >= 2; k--) add(1, 0, 0, 0, 0, 1, 0, 0, 3'b111, 4'(k), 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 0, 0, 0);
        add(1, 1, 5, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 1, 32'hFFFF_FFFF);
        // mthi/mfhi and mtlo/mflo back to back, never stalled
        add(1, 1, 7, 32'hDEAD_0001, 0, 0, 0, 1, 3'b001, 0, 0, 1, 32'hFFFF_FFFF);
        add(1, 1, 5, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        add(1, 1, 8, 32'h55, 0, 0, 0, 1, 3'b000, 0, 1, 1, 32'hDEAD_0001);
        add(0, 1, 6, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 1, 32'h55);
        // multu with non-MD instructions in D: never stalled, pend still counts
        add(0, 1, 2, 32'd3, 32'd3, 0, 1, 0, 3'b010, 0, 0, 1, 32'h55);
        for (int k = 5; k >= 1; k--) add(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 4'(k), 0, 0, 0);
        // reserved type and bubble-gated mult decode as idle
        add(1, 1, 9, 32'h1234, 32'h5678, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        // divu 100/7 then mflo
        add(1, 1, 4, 32'd100, 32'd7, 1, 1, 0, 3'b100, 0, 0, 0, 0);
        for (int k = 10; k >= 2; k--) add(1, 0, 0, 0, 0, 1, 0, 0, 3'b111, 4'(k), 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 0, 0, 0);
        add(0, 1, 6, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 1, 32'd14);

        // reset state; combinational decode follows its inputs during reset
        step();
        drive(1, 1, 1, 32'd7, 32'd6);
        step();
        @(negedge clk);
        chk("rst_pend", 32'(dut.pend), 0);
        chk("rst_wen", 32'(M_md_wen), 0);
        chk("rst_res", M_md_res, 0);
        chk("rst_err", 32'(md_err), 0);
        chk("rst_start", 32'(mif.start), 1);
        chk("rst_op", 32'(mif.MDU_op), 32'b011);
        chk("rst_stall", 32'(stall_D), 1);
        step();
        chk("rst_pend_held", 32'(dut.pend), 0);
        res = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d_md, vecs[i].e_valid, vecs[i].typ, vecs[i].rs, vecs[i].rt);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall_D), 32'(vecs[i].x_stall));
            chk($sformatf("v%0d_start", i), 32'(mif.start), 32'(vecs[i].x_start));
            chk($sformatf("v%0d_mt", i), 32'(mif.mt), 32'(vecs[i].x_mt));
            chk($sformatf("v%0d_op", i), 32'(mif.MDU_op), 32'(vecs[i].x_op));
            chk($sformatf("v%0d_a", i), mif.A, vecs[i].rs);
            chk($sformatf("v%0d_b", i), mif.B, vecs[i].rt);
            chk($sformatf("v%0d_pend", i), 32'(dut.pend), 32'(vecs[i].x_pend));
            chk($sformatf("v%0d_wen", i), 32'(M_md_wen), 32'(vecs[i].x_wen));
            if (vecs[i].chk_res) chk($sformatf("v%0d_res", i), M_md_res, vecs[i].x_res);
            chk($sformatf("v%0d_err", i), 32'(md_err), 0);
            step();
        end

        // reset in the middle of a divide (asserted at C4)
        drive(1, 1, 3, 32'd50, 32'd5);
        step();
        drive(1, 0, 0, 0, 0);
        step(); step(); step();
        res = 1'b1;
        @(negedge clk);
        chk("mid_rst_pend_c4", 32'(dut.pend), 7);
        chk("mid_rst_stall_c4", 32'(stall_D), 1);
        step();
        res = 1'b0;
        @(negedge clk);
        chk("mid_rst_pend", 32'(dut.pend), 0);
        chk("mid_rst_stall", 32'(stall_D), 0);
        chk("mid_rst_wen", 32'(M_md_wen), 0);
        chk("mid_rst_err", 32'(md_err), 0);
        chk("mid_rst_busy", 32'(mif.busy), 0);
        step();

        // busy asserted while pend==0
        busy_force = 1'b1;
        step();
        busy_force = 1'b0;
        @(negedge clk);
`ifdef MDU_ISSUE_CHECK_EN
        chk("err_set", 32'(md_err), 1);
        step(); step(); step();
        chk("err_sticky", 32'(md_err), 1);
`else
        chk("err_tied", 32'(md_err), 0);
        step(); step(); step();
        chk("err_tied_later", 32'(md_err), 0);
`endif
        res = 1'b1;
        step();
        res = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(md_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mdu_issue.md
# mdu_issue

E-stage issue controller placed directly in front of `MDU`. Classifies the E-stage instruction, drives `MDU`'s `start`/`mt`/`MDU_op`/`A`/`B`, and tracks the multiply/divide latency with its own countdown so that D-stage multiply/divide-class instructions stall in exactly the required cycles. Also registers the `mfhi`/`mflo` result into the E/M pipeline slot.

## Interface
- `MUL_LAT`, default 5: cycles `MDU` holds `busy` for `mult`/`multu`.
- `DIV_LAT`, default 10: cycles `MDU` holds `busy` for `div`/`divu`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `res`  in  1  reset, synchronous, active-high.
- `D_md`  in  1  D-stage instruction is MD-class (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
- `E_valid`  in  1  E-stage slot holds a real instruction (0 = bubble).
- `E_md_type`  in  4  E-stage MD op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none.
- `E_rs`, `E_rt`  in  32  forwarded E-stage operands.
- `busy`, `HI`, `LO`  in  1/32/32  from `MDU`.
- `start`, `mt`  out  1  to `MDU`.
- `MDU_op`  out  3  to `MDU`.
- `A`, `B`  out  32  to `MDU`; `A` = `E_rs`, `B` = `E_rt` unconditionally.
- `stall_D`  out  1  freeze PC and F/D; insert a bubble into D/E.
- `M_md_res`  out  32  registered `mfhi`/`mflo` value for M stage.
- `M_md_wen`  out  1  registered: `M_md_res` is valid this cycle.
- `md_err`  out  1  sticky consistency error.

## Operation
- Decode (combinational, gated by `E_valid`):
  - mult → `start`=1, `MDU_op`=3'b011; multu → 3'b010.
  - div → `start`=1, 3'b101; divu → 3'b100.
  - mtlo → `mt`=1, 3'b000; mthi → `mt`=1, 3'b001.
  - Otherwise `start`=`mt`=0 and `MDU_op`=3'b111, which `MDU` ignores.
- Countdown register `pend` (4 bits):
  - On `start`, load `MUL_LAT` or `DIV_LAT`.
  - Else, if nonzero, decrement.
- `stall_D` = `D_md` & (`start` | `pend` > 1). The final busy cycle (`pend`==1) is not stalled, because `MDU` updates HI/LO on that edge.
- Result register:
  - For mfhi/mflo: `M_md_res` <= `HI`/`LO`, `M_md_wen` <= 1.
  - Otherwise `M_md_wen` <= 0 and `M_md_res` holds its value.
  - Reads use the `HI`/`LO` values present in E; stall guarantees they are final.
- Reset: `pend`=0, `M_md_res`=0, `M_md_wen`=0, `md_err`=0.
  - Combinational outputs follow their inputs during reset.
  - Reset mid-operation discards `pend`; `MDU` is reset by the same `res`.
- Boundaries:
  - E holds a bubble while `pend`>1 → outputs idle, `pend` keeps counting.
  - MD-class instruction in E while `pend`>1 → must not occur (stall prevents it). Treated as a consistency error (see Configuration). `start` still drives high; `MDU` ignores it because its counter is nonzero.
  - mt in the cycle after the last busy cycle → legal; HI/LO are already final.
  - Back-to-back mult → the second instruction reaches E in C6 (see Timing), where `MDU`'s counter is 0 and the new `start` is accepted.

## Timing
- C0 = cycle with `start`=1 in E.
  - mult: `busy`=1 in C1–C5; `pend`=5..1 in C1..C5; new HI/LO visible from C6.
  - div: same pattern, C1–C10, HI/LO visible from C11.
- D-stage MD instruction:
  - mult: stalled C0–C4, enters E in C6.
  - div: stalled C0–C9, enters E in C11.
- `mt` takes effect in `MDU` on the C0 edge; no stall afterward.
- `M_md_res`/`M_md_wen`: one-cycle latency from E.

## Configuration
- `MDU_ISSUE_CHECK_EN` defined: each cycle after reset, `md_err` is set and held until `res` if either holds:
  - `busy` != (`pend` != 0);
  - (`start` | `mt`) while `pend` > 1.
- `MDU_ISSUE_CHECK_EN` undefined: `md_err` is tied to 0 and the checker logic is absent.

## Test plan
- Mult stall: E=mult, `E_rs`=7, `E_rt`=6, `D_md`=1 held → `stall_D`=1 in C0–C4, 0 in C5; `MDU_op`=3'b011 in C0; mflo in E at C6 → `M_md_res`=42 in C7.
- Div latency: div with `E_rs`=-7, `E_rt`=2, followed by mfhi → stall C0–C9; mfhi enters E in C11; `M_md_res`=32'hFFFFFFFF, `M_md_wen`=1.
- mthi then mfhi: mthi `E_rs`=32'hDEAD0001, then mfhi → no stall; `M_md_res`=32'hDEAD0001.
- Reset mid-divide: `res`=1 at C4 → `pend`=0, `stall_D`=0 next cycle, `M_md_wen`=0, `md_err`=0.
- Non-MD instruction in D during mult (`D_md`=0) → `stall_D`=0 throughout, `pend` still counts 5→0.
- Checker (`MDU_ISSUE_CHECK_EN`): force `busy`=1 while `pend`=0 → `md_err`=1 next cycle and stays 1 until `res`.
